la_wave_render: RTL and testbench
=================================

Name: la_wave_render

Overview:
- Pixel-pipeline stage between the 1080p timing generator and the HDMI output (r/g/b/vs/hs/de).
- Consumes vs/hs/de and active x/y from the timing generator.
- Reads logic-analyzer capture memory, one word per sample with one bit per channel, and draws each channel as a two-level trace in its own horizontal band.
- Overlays a grid and a vertical cursor; sync outputs are delay-matched to the pixel data.

Parameters:
X_BITS, 12, width of act_x/cursor_x
Y_BITS, 12, width of act_y
H_ACT, 1920, active pixels per line
V_ACT, 1080, active lines per frame
CH_NUM, 8, channels (bits per sample word)
ADDR_BITS, 11, capture memory address width
TOP_MARGIN, 60, first active line of band 0
BAND_H, 120, lines per channel band
HIGH_OFS, 20, row within band for logic-1 level
LOW_OFS, 80, row within band for logic-0 level
GRID_PITCH, 100, vertical grid spacing in pixels

Ports:
pix_clk  in  1  pixel clock
rstn  in  1  asynchronous active-low reset
vs_in  in  1  vertical sync from timing generator, active high
hs_in  in  1  horizontal sync, active high
de_in  in  1  data enable
act_x  in  X_BITS  active column, valid when de_in=1
act_y  in  Y_BITS  active line, valid when de_in=1
disp_en  in  1  enable trace drawing (frame-latched)
start_addr  in  ADDR_BITS  sample address shown at column 0 (frame-latched)
zoom_shift  in  3  samples advance every 2^zoom_shift pixels (frame-latched)
cursor_x  in  X_BITS  cursor column; >=H_ACT disables the cursor (frame-latched)
rd_addr  out  ADDR_BITS  capture RAM read address
rd_data  in  CH_NUM  capture RAM data, valid 1 cycle after rd_addr
vs_out/hs_out/de_out  out  1 each  delayed syncs
r_out/g_out/b_out  out  8 each  pixel colour

Behaviour:
- Reset (rstn=0, asynchronous): all outputs 0, rd_addr 0, all pipeline registers 0. Shadow registers reset to disp_en_s=0, start_s=0, zoom_s=0, cursor_s=all ones.
- Frame latch: on the pix_clk edge where vs_in goes 0->1, load disp_en, start_addr, zoom_shift and cursor_x into shadow registers. Mid-frame input changes have no effect until then.
- Pipeline: inputs at cycle t.
  - t+1: rd_addr = (start_s + (act_x >> zoom_s)) mod 2^ADDR_BITS, with wrap-around; geometry (channel, row, in_band, grid, cursor flags) registered.
  - t+2: rd_data valid; capture it.
  - t+3: colour and delayed syncs registered on the outputs.
  - Fixed latency is 3 cycles for vs/hs/de and colour.
- Geometry: y_rel = act_y - TOP_MARGIN.
  - in_band = (act_y >= TOP_MARGIN) and (y_rel < CH_NUM*BAND_H).
  - ch = y_rel / BAND_H; row = y_rel - ch*BAND_H.
  - Implement with a compare chain or per-line counters; no generic divider.
- Previous sample: prev holds the rd_data captured in the preceding de=1 cycle. On the first pixel of a line (act_x=0), prev = current sample.
- Trace lit when in_band and disp_en_s, with b = rd_data[ch], p = prev[ch], and any of:
  - b=1 and row=HIGH_OFS
  - b=0 and row=LOW_OFS
  - b!=p and HIGH_OFS<=row<=LOW_OFS (vertical edge)
- Grid lit when in_band and either row=0 or the column counter is 0. The column counter runs 0..GRID_PITCH-1 and is cleared at act_x=0.
- Cursor lit when cursor_s < H_ACT and act_x = cursor_s, on all active lines.
- Colour priority, evaluated on delayed signals:
  1. de=0 -> 000000
  2. cursor -> FFFFFF
  3. trace -> 00FF00
  4. grid -> 404040
  5. else -> 000000
- disp_en_s=0 suppresses trace only; grid and cursor are still drawn.
- zoom_shift>0: consecutive pixels read the same sample, so no edge is drawn within a run.
- Reset mid-frame: outputs drop to 0 immediately. After release, traces stay off until a vs_in rise latches disp_en=1.

Test Plan:
1. rstn pulsed low mid-line -> all outputs and rd_addr 0 in the same cycle. After release with disp_en=1, no green pixels until the first vs_in 0->1.
2. Random vs/hs/de stream -> vs_out/hs_out/de_out equal inputs delayed exactly 3 cycles; r/g/b=0 whenever de_out=0.
3. start_addr=2040, zoom_shift=1 latched, act_x=20 -> rd_addr=2 on the next cycle; act_x=21 -> rd_addr=2 again.
4. rd_data bit0 constant 1, disp_en=1:
   - act_y=80, x=150 -> output 00FF00.
   - act_y=140, x=150 -> 000000.
   - act_y=140, x=200 -> 404040.
5. Channel 3 sample 0 at x=500 and 1 at x=501, zoom 0 -> at x=501, lines 440..500 -> 00FF00. At x=502, only line 440 is green.
6. cursor_x changed to 700 mid-frame -> no white column that frame. After the next vs_in rise:
   - column 700 is FFFFFF on all active lines, including line 80 with a trace.
   - cursor_x=1920 -> no cursor.

Source files
------------

// File: rtl/la_wave_render.sv
`default_nettype none
// ============================================================================
//  Module      : la_wave_render
//  Description : Logic-analyzer waveform renderer. Reads one capture word per
//                pixel column, draws each channel as a two-level trace in its
//                own horizontal band, overlays a grid and a vertical cursor,
//                and delays syncs to stay aligned with the pixel colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_wave_render #(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int H_ACT      = 1920,
    parameter int V_ACT      = 1080,
    parameter int CH_NUM     = 8,
    parameter int ADDR_BITS  = 11,
    parameter int TOP_MARGIN = 60,
    parameter int BAND_H     = 120,
    parameter int HIGH_OFS   = 20,
    parameter int LOW_OFS    = 80,
    parameter int GRID_PITCH = 100
) (
    input  logic                 pix_clk,
    input  logic                 rstn,
    input  logic                 vs_in,
    input  logic                 hs_in,
    input  logic                 de_in,
    input  logic [X_BITS-1:0]    act_x,
    input  logic [Y_BITS-1:0]    act_y,
    input  logic                 disp_en,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [2:0]           zoom_shift,
    input  logic [X_BITS-1:0]    cursor_x,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [CH_NUM-1:0]    rd_data,
    output logic                 vs_out,
    output logic                 hs_out,
    output logic                 de_out,
    output logic [7:0]           r_out,
    output logic [7:0]           g_out,
    output logic [7:0]           b_out
);

    localparam int c_CH_BITS  = (CH_NUM > 1)     ? $clog2(CH_NUM)     : 1;
    localparam int c_ROW_BITS = (BAND_H > 1)     ? $clog2(BAND_H)     : 1;
    localparam int c_COL_BITS = (GRID_PITCH > 1) ? $clog2(GRID_PITCH) : 1;

    // Frame-latched shadow copies of the control inputs
    logic                 r_vs_d;
    logic                 r_disp_s;
    logic [ADDR_BITS-1:0] r_start_s;
    logic [2:0]           r_zoom_s;
    logic [X_BITS-1:0]    r_cursor_s;

    // Grid column counter (position within the current grid pitch)
    logic [c_COL_BITS-1:0] r_col;

    // Stage 1 (address issued, geometry registered)
    logic                  r1_vs, r1_hs, r1_de, r1_trace_en, r1_grid, r1_cursor, r1_first;
    logic [c_CH_BITS-1:0]  r1_ch;
    logic [c_ROW_BITS-1:0] r1_row;

    // Stage 2 (capture data arriving from RAM)
    logic                  r2_vs, r2_hs, r2_de, r2_trace_en, r2_grid, r2_cursor, r2_first;
    logic [c_CH_BITS-1:0]  r2_ch;
    logic [c_ROW_BITS-1:0] r2_row;
    logic [CH_NUM-1:0]     r_last;

    logic [Y_BITS-1:0]     w_y_rel;
    logic [Y_BITS-1:0]     w_base;
    logic                  w_in_band;
    logic [c_CH_BITS-1:0]  w_ch;
    logic [c_ROW_BITS-1:0] w_row;
    logic [c_COL_BITS-1:0] w_col_cur;
    logic                  w_cursor;
    logic [ADDR_BITS-1:0]  w_rd_addr;
    logic [CH_NUM-1:0]     w_prev_word;
    logic                  w_b, w_p, w_trace;

    // Latch the display controls on the rising edge of vertical sync
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_vs_d     <= 1'b0;
            r_disp_s   <= 1'b0;
            r_start_s  <= '0;
            r_zoom_s   <= '0;
            r_cursor_s <= '1;
        end else begin
            r_vs_d <= vs_in;
            if (vs_in && !r_vs_d) begin
                r_disp_s   <= disp_en;
                r_start_s  <= start_addr;
                r_zoom_s   <= zoom_shift;
                r_cursor_s <= cursor_x;
            end
        end
    end

    // Band geometry by compare chain: channel index and row within its band
    always_comb begin
        w_y_rel   = act_y - Y_BITS'(TOP_MARGIN);
        w_in_band = (act_y >= Y_BITS'(TOP_MARGIN)) && (w_y_rel < Y_BITS'(CH_NUM * BAND_H));
        w_ch      = '0;
        w_base    = '0;
        for (int i = 1; i < CH_NUM; i++) begin
            if (w_y_rel >= Y_BITS'(i * BAND_H)) begin
                w_ch   = c_CH_BITS'(i);
                w_base = Y_BITS'(i * BAND_H);
            end
        end
        w_row = c_ROW_BITS'(w_y_rel - w_base);
    end

    // Column position inside the grid pitch, cursor hit and sample address
    always_comb begin
        w_col_cur = (act_x == '0) ? '0 : r_col;
        w_cursor  = (r_cursor_s < X_BITS'(H_ACT)) && (act_x == r_cursor_s);
        w_rd_addr = r_start_s + ADDR_BITS'(act_x >> r_zoom_s);
    end

    // Grid column counter advances once per active pixel, restarting at x=0
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_col <= '0;
        end else if (de_in) begin
            r_col <= (w_col_cur == c_COL_BITS'(GRID_PITCH - 1)) ? '0 : w_col_cur + 1'b1;
        end
    end

    // Stage 1: issue RAM address and register per-pixel geometry flags
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr     <= '0;
            r1_vs       <= 1'b0;
            r1_hs       <= 1'b0;
            r1_de       <= 1'b0;
            r1_trace_en <= 1'b0;
            r1_grid     <= 1'b0;
            r1_cursor   <= 1'b0;
            r1_first    <= 1'b0;
            r1_ch       <= '0;
            r1_row      <= '0;
        end else begin
            rd_addr     <= w_rd_addr;
            r1_vs       <= vs_in;
            r1_hs       <= hs_in;
            r1_de       <= de_in;
            r1_trace_en <= w_in_band && r_disp_s;
            r1_grid     <= w_in_band && ((w_row == '0) || (w_col_cur == '0));
            r1_cursor   <= w_cursor;
            r1_first    <= (act_x == '0);
            r1_ch       <= w_ch;
            r1_row      <= w_row;
        end
    end

    // Stage 2: hold geometry while the RAM returns the sample word
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r2_vs       <= 1'b0;
            r2_hs       <= 1'b0;
            r2_de       <= 1'b0;
            r2_trace_en <= 1'b0;
            r2_grid     <= 1'b0;
            r2_cursor   <= 1'b0;
            r2_first    <= 1'b0;
            r2_ch       <= '0;
            r2_row      <= '0;
        end else begin
            r2_vs       <= r1_vs;
            r2_hs       <= r1_hs;
            r2_de       <= r1_de;
            r2_trace_en <= r1_trace_en;
            r2_grid     <= r1_grid;
            r2_cursor   <= r1_cursor;
            r2_first    <= r1_first;
            r2_ch       <= r1_ch;
            r2_row      <= r1_row;
        end
    end

    // Remember the sample of the previous active pixel for edge drawing
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= '0;
        end else if (r2_de) begin
            r_last <= rd_data;
        end
    end

    // Trace decision: high level, low level, or vertical edge between them
    always_comb begin
        w_prev_word = r2_first ? rd_data : r_last;
        w_b         = rd_data[r2_ch];
        w_p         = w_prev_word[r2_ch];
        w_trace     = r2_trace_en &&
                      ((w_b  && (r2_row == c_ROW_BITS'(HIGH_OFS))) ||
                       (!w_b && (r2_row == c_ROW_BITS'(LOW_OFS)))  ||
                       ((w_b != w_p) && (r2_row >= c_ROW_BITS'(HIGH_OFS)) &&
                                        (r2_row <= c_ROW_BITS'(LOW_OFS))));
    end

    // Stage 3: prioritised colour and delay-matched syncs
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            vs_out <= 1'b0;
            hs_out <= 1'b0;
            de_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else begin
            vs_out <= r2_vs;
            hs_out <= r2_hs;
            de_out <= r2_de;
            if (!r2_de) begin
                {r_out, g_out, b_out} <= 24'h000000;
            end else if (r2_cursor) begin
                {r_out, g_out, b_out} <= 24'hFFFFFF;
            end else if (w_trace) begin
                {r_out, g_out, b_out} <= 24'h00FF00;
            end else if (r2_grid) begin
                {r_out, g_out, b_out} <= 24'h404040;
            end else begin
                {r_out, g_out, b_out} <= 24'h000000;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_la_wave_render.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_la_wave_render
//  Description : Self-checking bench for la_wave_render with a behavioural
//                pixel model, a synchronous capture RAM and directed pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_la_wave_render;

    localparam int H_ACT      = 1920;
    localparam int CH_NUM     = 8;
    localparam int TOP_MARGIN = 60;
    localparam int BAND_H     = 120;
    localparam int HIGH_OFS   = 20;
    localparam int LOW_OFS    = 80;
    localparam int GRID_PITCH = 100;
    localparam int MEM_DEPTH  = 2048;

    logic        pix_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0, disp_en = 1'b0;
    logic [11:0] act_x = '0, act_y = '0, cursor_x = '1;
    logic [10:0] start_addr = '0;
    logic [2:0]  zoom_shift = '0;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic        vs_out, hs_out, de_out;
    logic [7:0]  r_out, g_out, b_out;

    logic [7:0]  mem [0:MEM_DEPTH-1];

    typedef struct packed {
        logic        vs, hs, de;
        logic [23:0] rgb;
        logic [11:0] x, y;
    } exp_t;

    typedef struct {
        int          x, y;
        logic [23:0] rgb;
    } watch_t;

    exp_t   expq[$];
    watch_t wq[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_disp;
    int         m_start, m_zoom, m_cursor;
    bit         m_vs_prev;
    logic [7:0] m_last;

    la_wave_render dut (
        .pix_clk   (pix_clk),
        .rstn      (rstn),
        .vs_in     (vs_in),
        .hs_in     (hs_in),
        .de_in     (de_in),
        .act_x     (act_x),
        .act_y     (act_y),
        .disp_en   (disp_en),
        .start_addr(start_addr),
        .zoom_shift(zoom_shift),
        .cursor_x  (cursor_x),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .vs_out    (vs_out),
        .hs_out    (hs_out),
        .de_out    (de_out),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
    );

    always #5 pix_clk = ~pix_clk;

    // Synchronous capture RAM: data one cycle after address
    always @(posedge pix_clk) rd_data <= mem[rd_addr];

    task automatic model_reset();
        exp_t z;
        m_disp = 1'b0; m_start = 0; m_zoom = 0; m_cursor = 4095;
        m_vs_prev = 1'b0; m_last = '0;
        expq.delete();
        z = '0;
        expq.push_back(z);
        expq.push_back(z);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert ({vs_out, hs_out, de_out, r_out, g_out, b_out, rd_addr} === '0)
        else begin
            errors++;
            $error("FAIL %s: observed vs/hs/de=%b%b%b rgb=%h rd_addr=%0d expected all zero",
                   tag, vs_out, hs_out, de_out, {r_out, g_out, b_out}, rd_addr);
        end
    endtask

    // One pixel clock: drive inputs, predict, then compare with output due now
    task automatic step(input logic vs, input logic hs, input logic de, input int x, input int y);
        exp_t       e;
        logic [7:0] cur, pw;
        int         a, yr, ch, row;
        bit         inb, trace, grid, cur_on;
        logic       b, p;
        vs_in = vs; hs_in = hs; de_in = de;
        act_x = 12'(x); act_y = 12'(y);

        a   = (m_start + (x >> m_zoom)) % MEM_DEPTH;
        cur = mem[a];
        pw  = (x == 0) ? cur : m_last;
        yr  = y - TOP_MARGIN;
        inb = (y >= TOP_MARGIN) && (yr < CH_NUM * BAND_H);
        ch  = inb ? yr / BAND_H : 0;
        row = inb ? yr % BAND_H : 0;
        b   = cur[ch];
        p   = pw[ch];
        trace  = inb && m_disp && ((b && row == HIGH_OFS) || (!b && row == LOW_OFS) ||
                                   (b != p && row >= HIGH_OFS && row <= LOW_OFS));
        grid   = inb && (row == 0 || (x % GRID_PITCH) == 0);
        cur_on = (m_cursor < H_ACT) && (x == m_cursor);
        e.vs = vs; e.hs = hs; e.de = de;
        e.x  = 12'(x); e.y = 12'(y);
        e.rgb = !de ? 24'h0 : cur_on ? 24'hFFFFFF : trace ? 24'h00FF00 : grid ? 24'h404040 : 24'h0;
        if (de) m_last = cur;
        if (vs && !m_vs_prev) begin
            m_disp = disp_en; m_start = int'(start_addr);
            m_zoom = int'(zoom_shift); m_cursor = int'(cursor_x);
        end
        m_vs_prev = vs;
        expq.push_back(e);

        @(posedge pix_clk); #1;
        checks++;
        assert (rd_addr === 11'(a))
        else begin
            errors++;
            $error("FAIL rd_addr: observed %0d expected %0d", rd_addr, a);
        end
        if (expq.size() == 3) begin
            e = expq.pop_front();
            checks++;
            assert ({vs_out, hs_out, de_out} === {e.vs, e.hs, e.de})
            else begin
                errors++;
                $error("FAIL syncs x=%0d y=%0d: observed %b expected %b",
                       e.x, e.y, {vs_out, hs_out, de_out}, {e.vs, e.hs, e.de});
            end
            checks++;
            assert ({r_out, g_out, b_out} === e.rgb)
            else begin
                errors++;
                $error("FAIL colour x=%0d y=%0d: observed %h expected %h",
                       e.x, e.y, {r_out, g_out, b_out}, e.rgb);
            end
            for (int i = 0; i < wq.size(); i++) begin
                if (e.de && wq[i].x == int'(e.x) && wq[i].y == int'(e.y)) begin
                    checks++;
                    assert ({r_out, g_out, b_out} === wq[i].rgb)
                    else begin
                        errors++;
                        $error("FAIL pixel(%0d,%0d): observed %h expected %h",
                               wq[i].x, wq[i].y, {r_out, g_out, b_out}, wq[i].rgb);
                    end
                    wq.delete(i);
                    break;
                end
            end
        end
    endtask

    task automatic watch(input int x, input int y, input logic [23:0] rgb);
        watch_t w;
        w.x = x; w.y = y; w.rgb = rgb;
        wq.push_back(w);
    endtask

    task automatic watches_done(input string tag);
        checks++;
        assert (wq.size() == 0)
        else begin
            errors++;
            $error("FAIL %s: observed %0d directed pixels unreached expected 0", tag, wq.size());
            wq.delete();
        end
    endtask

    task automatic drive_line(input int y, input int xend);
        for (int x = 0; x <= xend; x++) step(1'b0, 1'b0, 1'b1, x, y);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 0, y);
    endtask

    task automatic frame_start();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int xc, yc;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'($urandom);

        // Power-on reset
        repeat (3) @(posedge pix_clk);
        #1;
        check_reset_outputs("por");
        rstn = 1'b1;
        model_reset();

        // Random sync/data stream with random frame-latched controls
        xc = 0; yc = 100;
        for (int n = 0; n < 3000; n++) begin
            logic vs, hs, de;
            disp_en    = 1'($urandom);
            start_addr = 11'($urandom);
            zoom_shift = 3'($urandom_range(0, 3));
            cursor_x   = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1920, 4095))
                                                     : 12'($urandom_range(0, 150));
            vs = (n % 400) < 3;
            hs = ($urandom_range(0, 7) == 0);
            de = !vs && !hs && ($urandom_range(0, 3) != 0);
            if ((n % 160) == 0) begin
                xc = 0;
                yc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1079)
                                                 : TOP_MARGIN + $urandom_range(0, 959);
            end
            step(vs, hs, de, xc, yc);
            if (de) xc++;
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 0, 0);

        // Reset mid-line: outputs clear at once, traces stay off until vs rise
        for (int i = 0; i < MEM_DEPTH; i++) mem[i][0] = 1'b1;
        disp_en = 1'b1; start_addr = '0; zoom_shift = '0; cursor_x = 12'd1920;
        frame_start();
        for (int x = 0; x < 40; x++) step(1'b0, 1'b0, 1'b1, x, 80);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(posedge pix_clk); #1;
        check_reset_outputs("reset_held");
        rstn = 1'b1;
        model_reset();
        watch(150, 80, 24'h000000);
        drive_line(80, 160);
        watches_done("after_reset_no_trace");
        frame_start();
        watch(150, 80, 24'h00FF00);
        drive_line(80, 160);
        watch(150, 140, 24'h000000);
        watch(200, 140, 24'h404040);
        drive_line(140, 210);
        watches_done("band0_level_grid");

        // Address wrap with zoom
        start_addr = 11'd2040; zoom_shift = 3'd1;
        frame_start();
        step(1'b0, 1'b0, 1'b1, 20, 30);
        checks++;
        assert (rd_addr === 11'd2) else begin
            errors++; $error("FAIL wrap_x20: observed %0d expected 2", rd_addr);
        end
        step(1'b0, 1'b0, 1'b1, 21, 30);
        checks++;
        assert (rd_addr === 11'd2) else begin
            errors++; $error("FAIL wrap_x21: observed %0d expected 2", rd_addr);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 0, 30);

        // Rising edge on channel 3 at x=501
        mem[500][3] = 1'b0; mem[501][3] = 1'b1; mem[502][3] = 1'b1;
        start_addr = '0; zoom_shift = '0;
        frame_start();
        watch(501, 439, 24'h000000);
        drive_line(439, 505);
        watch(501, 440, 24'h00FF00); watch(502, 440, 24'h00FF00);
        drive_line(440, 505);
        watch(501, 441, 24'h00FF00); watch(502, 441, 24'h000000);
        drive_line(441, 505);
        watch(501, 470, 24'h00FF00);
        drive_line(470, 505);
        watch(501, 500, 24'h00FF00); watch(502, 500, 24'h000000);
        drive_line(500, 505);
        watch(501, 501, 24'h000000);
        drive_line(501, 505);
        watches_done("ch3_edge");

        // Cursor: mid-frame change ignored, then latched, then disabled
        cursor_x = 12'd700;
        watch(700, 80, 24'h00FF00);
        drive_line(80, 702);
        watch(700, 30, 24'h000000);
        drive_line(30, 702);
        watches_done("cursor_not_yet");
        frame_start();
        watch(700, 80, 24'hFFFFFF);
        drive_line(80, 702);
        watch(700, 30, 24'hFFFFFF);
        drive_line(30, 702);
        watch(700, 1079, 24'hFFFFFF);
        drive_line(1079, 702);
        watches_done("cursor_on");
        cursor_x = 12'd1920;
        frame_start();
        watch(700, 30, 24'h000000);
        drive_line(30, 702);
        watches_done("cursor_off");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
